rf_read_arbiter: RTL and testbench
==================================

// Module: rf_read_arbiter
// PURPOSE
//  Shares one register-file read path (32:1 mux tree, 5-bit SEL) between NREQ requesters.
//  Round-robin arbitration; drives the mux select from a register; captures mux output.
//  Returns a tagged response under valid/ready backpressure.
//  Sits between decode/debug read clients and the register-file read mux.
// PARAMETERS
//  NREQ  4   number of requesters (2..8)
//  AW    5   register address width (drives mux SEL)
//  DW    32  register data width
//  IW    2   requester-ID width, = clog2(NREQ)
// PORTS
//  CLK        in   1        clock, rising edge
//  RST        in   1        asynchronous, active-high reset
//  REQ_VALID  in   NREQ     request valid, one bit per requester
//  REQ_ADDR   in   NREQ*AW  register address; requester i uses bits [i*AW +: AW]
//  REQ_READY  out  NREQ     one-hot grant; request i accepted when VALID[i] & READY[i]
//  MUX_SEL    out  AW       select to the read mux; always driven from a flop
//  MUX_DATA   in   DW       read-mux output for MUX_SEL
//  RSP_VALID  out  1        response valid
//  RSP_ID     out  IW       requester index of the response
//  RSP_ADDR   out  AW       address of the response
//  RSP_DATA   out  DW       register data
//  RSP_READY  in   1        response consumer ready
// BEHAVIOUR
//  Reset (async, RST=1): pipeline valid bits=0; RSP_VALID=0; RSP_ID/ADDR/DATA=0; MUX_SEL=0.
//   Round-robin pointer=0; REQ_READY=0 while RST is high.
//  Two-stage pipeline:
//   S1 (sel_q, id_q, v1) holds the granted address; MUX_SEL = sel_q.
//   S2 (RSP_*) samples MUX_DATA at the end of the cycle in which S1 is valid and advances.
//  Latency: accept in cycle N -> RSP_VALID high in cycle N+2. Throughput: 1 request/cycle.
//  Stall: stall2 = RSP_VALID & ~RSP_READY.
//   adv1 = v1 & ~stall2.
//   load1 = ~v1 | adv1.
//  REQ_READY = grant & {NREQ{load1}}; grant is combinational, one-hot or zero.
//  Arbitration:
//   Scan starts at pointer and searches upward with wrap-around; first valid requester wins.
//   After an accept, pointer = winner+1 mod NREQ. With no accept, pointer holds.
//  When S1 is empty, MUX_SEL holds its last value; it does not toggle on idle cycles.
//  S2 updates only when ~stall2. If ~v1 & ~stall2, RSP_VALID clears and the data fields hold.
//  Under stall, RSP_* and S1 hold. REQ_READY=0 only if S1 is full and stalled.
//  A requester must hold VALID/ADDR until accepted. Dropping VALID early is legal; nothing is queued.
//  Address 0 gets no special treatment; any zero-register rule belongs to the mux/regfile.
//  Simultaneous RSP handshake and new accept in the same cycle: both take effect, giving full throughput.
//  Reset mid-operation: in-flight requests are discarded and no response is issued for them.
// STRUCTURE
//  Shared include proc_defs.vh: `REG_AW (5), `REG_DW (32).
//  Sub-module rr_arbiter (NREQ): inputs req vector and pointer; output one-hot grant and winner index.
//   Purely combinational.
//  Pointer, pipeline flops and stall logic live in rf_read_arbiter.
//  The bench instantiates the real 32:1 mux tree on MUX_SEL/MUX_DATA with a preloaded register array.
// TESTING
//  1. Reset mid-stream:
//     assert RST while v1 and RSP_VALID are 1 -> all outputs 0 immediately.
//     After release, the first grant goes to requester 0.
//  2. Single request:
//     REQ_VALID=0001, addr=5'd7, reg[7]=32'hDEADBEEF -> REQ_READY=0001 in cycle 0.
//     MUX_SEL=7 in cycle 1; RSP_VALID with ID=0, DATA=DEADBEEF in cycle 2.
//  3. Round robin:
//     REQ_VALID=1111 held, RSP_READY=1 -> grants 0,1,2,3,0 in consecutive cycles.
//     Responses arrive in the same order, one per cycle.
//  4. Backpressure:
//     RSP_READY=0 for 3 cycles after the first response -> RSP_* stable, S1 holds.
//     REQ_READY=0 once S1 is full. After release, no response is lost or duplicated.
//  5. Wrap and skip:
//     pointer=3, REQ_VALID=0101 -> grant requester 0, then 2.
//     Addresses 31 and 16 return reg[31] and reg[16] (both mux halves exercised).
//  6. Random soak:
//     10k cycles of random VALID/ADDR/RSP_READY against the scoreboard model.
//     Per requester, responses stay in order with correct data.
//     No starvation: any requester held valid is granted within NREQ accepts.

Source files
------------

// File: rtl/rf_read_arbiter_pkg.sv
// Shared widths and index helpers for the register-file read arbiter.
package rf_read_arbiter_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam int STAGES = 2;

  // Fold x in [0, 2n) back into [0, n).
  function automatic int wrap_idx(input int x, input int n);
    return (x >= n) ? x - n : x;
  endfunction
endpackage

// File: rtl/rf_read_arbiter_if.sv
// Request/mux/response bundle between read clients, the arbiter and the regfile read mux.
interface rf_read_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = rf_read_arbiter_pkg::REG_AW,
  parameter int DW   = rf_read_arbiter_pkg::REG_DW,
  parameter int IW   = $clog2(NREQ)
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0][AW-1:0] req_addr;
  logic [NREQ-1:0]         req_ready;
  logic [AW-1:0]           mux_sel;
  logic [DW-1:0]           mux_data;
  logic                    rsp_valid;
  logic [IW-1:0]           rsp_id;
  logic [AW-1:0]           rsp_addr;
  logic [DW-1:0]           rsp_data;
  logic                    rsp_ready;

  modport slave (
    input  req_valid, req_addr, mux_data, rsp_ready,
    output req_ready, mux_sel, rsp_valid, rsp_id, rsp_addr, rsp_data
  );
  modport master (
    output req_valid, req_addr, mux_data, rsp_ready,
    input  req_ready, mux_sel, rsp_valid, rsp_id, rsp_addr, rsp_data
  );
endinterface

// File: rtl/rf_read_arbiter_rr.sv
// Combinational round-robin pick: scan upward from ptr_i with wrap, first set bit wins.
module rr_arbiter
  import rf_read_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   win_o
);
  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    win_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'(wrap_idx(int'(ptr_i) + k, NREQ));
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        win_o      = idx;
      end
    end
  end
endmodule

// File: rtl/rf_read_arbiter.sv
// Round-robin sharing of one regfile read mux: S1 drives MUX_SEL from a flop, S2 captures data.
module rf_read_arbiter
  import rf_read_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  rf_read_arbiter_if.slave bus
);
  logic [STAGES:1] vld_pipe_q, vld_pipe_d;
  logic [AW-1:0]   sel_q, sel_d;
  logic [IW-1:0]   id_q, id_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   rsp_id_q, rsp_id_d;
  logic [AW-1:0]   rsp_addr_q, rsp_addr_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   win;
  logic            stall2, adv1, load1, accept;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .win_o (win)
  );

  assign stall2 = vld_pipe_q[2] & ~bus.rsp_ready;
  assign adv1   = vld_pipe_q[1] & ~stall2;
  assign load1  = ~vld_pipe_q[1] | adv1;
  // Grants are suppressed combinationally while reset is held, not just after the flops clear.
  assign bus.req_ready = rst_i ? '0 : (gnt & {NREQ{load1}});
  assign accept        = |bus.req_ready;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    sel_d      = sel_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_addr_d = rsp_addr_q;
    rsp_data_d = rsp_data_q;
    if (load1) vld_pipe_d[1] = accept;
    // sel only moves on an accept, so the mux select stays quiet on idle cycles
    if (accept) begin
      sel_d = bus.req_addr[win];
      id_d  = win;
      ptr_d = IW'(wrap_idx(int'(win) + 1, NREQ));
    end
    if (!stall2) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      if (vld_pipe_q[1]) begin
        rsp_id_d   = id_q;
        rsp_addr_d = sel_q;
        rsp_data_d = bus.mux_data;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe_q <= '0;
      sel_q      <= '0;
      id_q       <= '0;
      ptr_q      <= '0;
      rsp_id_q   <= '0;
      rsp_addr_q <= '0;
      rsp_data_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      sel_q      <= sel_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign bus.mux_sel   = sel_q;
  assign bus.rsp_valid = vld_pipe_q[2];
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed table + hand sequences + scoreboarded random soak for rf_read_arbiter.
module tb_rf_read_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int IW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_read_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .IW(IW)) bus ();
  rf_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .IW(IW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  logic [DW-1:0] rf [32];
  assign bus.mux_data = rf[bus.mux_sel];

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] rf_val(input logic [4:0] a);
    if (a == 5'd7) return 32'hDEADBEEF;
    return 32'hC0DE_0000 | (32'(a) << 8) | 32'(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] v, input logic [19:0] a, input logic rr);
    @(posedge clk);
    #1;
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.rsp_ready = rr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [19:0] a;
    logic        rr;
    logic [3:0]  e_rdy;
    logic [4:0]  e_sel;
    logic        e_v;
    logic [1:0]  e_id;
    logic [4:0]  e_addr;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [3:0] v, input logic [19:0] a, input logic rr,
                     input logic [3:0] e_rdy, input logic [4:0] e_sel, input logic e_v,
                     input logic [1:0] e_id, input logic [4:0] e_addr);
    vec_t r;
    r.v = v; r.a = a; r.rr = rr; r.e_rdy = e_rdy; r.e_sel = e_sel;
    r.e_v = e_v; r.e_id = e_id; r.e_addr = e_addr;
    tbl.push_back(r);
  endtask

  typedef struct { logic [1:0] id; logic [4:0] addr; } sb_t;
  sb_t sb[$];

  initial begin
    logic [19:0] a0, a1, a2;
    logic [3:0]  cur_v, acc;
    logic [19:0] cur_a;
    logic        cur_rr, prev_v, prev_rr, hit;
    logic [1:0]  prev_id;
    logic [4:0]  prev_addr;
    logic [31:0] prev_data;
    int          wait_cnt [NREQ];

    for (int i = 0; i < 32; i++) rf[i] = rf_val(5'(i));
    a0 = {5'd0, 5'd0, 5'd0, 5'd7};
    a1 = {5'd31, 5'd16, 5'd7, 5'd1};
    a2 = {5'd31, 5'd16, 5'd7, 5'd31};
    bus.req_valid = 4'b1111;
    bus.req_addr  = a1;
    bus.rsp_ready = 1'b1;

    // reset state, with every requester asking
    @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_mux_sel",   bus.mux_sel, 0);
    chk("rst_rsp_id",    bus.rsp_id, 0);
    chk("rst_rsp_addr",  bus.rsp_addr, 0);
    chk("rst_rsp_data",  bus.rsp_data, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // reset mid-stream: S1 and S2 both occupied, then async reset
    step(4'b0110, a1, 1'b0);
    chk("mid_rdy0", bus.req_ready, 4'b0010);
    step(4'b0100, a1, 1'b0);
    chk("mid_rdy1", bus.req_ready, 4'b0100);
    step(4'b0000, a1, 1'b0);
    chk("mid_pre_valid", bus.rsp_valid, 1);
    chk("mid_pre_id",    bus.rsp_id, 1);
    chk("mid_pre_sel",   bus.mux_sel, 16);
    #2 rst = 1'b1;
    #1;
    chk("mid_rsp_valid", bus.rsp_valid, 0);
    chk("mid_mux_sel",   bus.mux_sel, 0);
    chk("mid_rsp_id",    bus.rsp_id, 0);
    chk("mid_rsp_data",  bus.rsp_data, 0);
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    #1;
    chk("mid_rdy_in_rst", bus.req_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_first_grant", bus.req_ready, 4'b0001);

    // single request
    do_reset();
    step(4'b0001, a0, 1'b1);
    chk("single_rdy", bus.req_ready, 4'b0001);
    step(4'b0000, a0, 1'b1);
    chk("single_sel", bus.mux_sel, 7);
    chk("single_v1",  bus.rsp_valid, 0);
    step(4'b0000, a0, 1'b1);
    chk("single_valid", bus.rsp_valid, 1);
    chk("single_id",    bus.rsp_id, 0);
    chk("single_addr",  bus.rsp_addr, 7);
    chk("single_data",  bus.rsp_data, 32'hDEADBEEF);
    step(4'b0000, a0, 1'b1);
    chk("single_done", bus.rsp_valid, 0);
    chk("single_hold", bus.rsp_data, 32'hDEADBEEF);

    // round robin, backpressure, wrap/skip
    do_reset();
    add(4'b1111, a1, 1, 4'b0001,  0, 0, 0,  0);
    add(4'b1111, a1, 1, 4'b0010,  1, 0, 0,  0);
    add(4'b1111, a1, 1, 4'b0100,  7, 1, 0,  1);
    add(4'b1111, a1, 1, 4'b1000, 16, 1, 1,  7);
    add(4'b1111, a1, 1, 4'b0001, 31, 1, 2, 16);
    add(4'b0000, a1, 1, 4'b0000,  1, 1, 3, 31);
    add(4'b0000, a1, 1, 4'b0000,  1, 1, 0,  1);
    add(4'b0000, a1, 1, 4'b0000,  1, 0, 0,  0);
    add(4'b1111, a1, 1, 4'b0010,  1, 0, 0,  0);
    add(4'b1111, a1, 1, 4'b0100,  7, 0, 0,  0);
    add(4'b1111, a1, 0, 4'b0000, 16, 1, 1,  7);
    add(4'b1111, a1, 0, 4'b0000, 16, 1, 1,  7);
    add(4'b1111, a1, 0, 4'b0000, 16, 1, 1,  7);
    add(4'b1111, a1, 1, 4'b1000, 16, 1, 1,  7);
    add(4'b0000, a1, 1, 4'b0000, 31, 1, 2, 16);
    add(4'b0000, a1, 1, 4'b0000, 31, 1, 3, 31);
    add(4'b0000, a1, 1, 4'b0000, 31, 0, 0,  0);
    add(4'b0100, a2, 1, 4'b0100, 31, 0, 0,  0);
    add(4'b0101, a2, 1, 4'b0001, 16, 0, 0,  0);
    add(4'b0100, a2, 1, 4'b0100, 31, 1, 2, 16);
    add(4'b0000, a2, 1, 4'b0000, 16, 1, 0, 31);
    add(4'b0000, a2, 1, 4'b0000, 16, 1, 2, 16);
    add(4'b0000, a2, 1, 4'b0000, 16, 0, 0,  0);
    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].v, tbl[k].a, tbl[k].rr);
      chk($sformatf("tbl[%0d].rdy", k),   bus.req_ready, tbl[k].e_rdy);
      chk($sformatf("tbl[%0d].sel", k),   bus.mux_sel,   tbl[k].e_sel);
      chk($sformatf("tbl[%0d].valid", k), bus.rsp_valid, tbl[k].e_v);
      if (tbl[k].e_v) begin
        chk($sformatf("tbl[%0d].id", k),   bus.rsp_id,   tbl[k].e_id);
        chk($sformatf("tbl[%0d].addr", k), bus.rsp_addr, tbl[k].e_addr);
        chk($sformatf("tbl[%0d].data", k), bus.rsp_data, rf_val(tbl[k].e_addr));
      end
    end

    // random soak against a per-requester in-order scoreboard
    do_reset();
    cur_v = '0; acc = '0; cur_a = '0;
    prev_v = 1'b0; prev_rr = 1'b1; prev_id = '0; prev_addr = '0; prev_data = '0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 10010; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (!cur_v[i] || acc[i]) begin
          cur_v[i] = (c < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
          cur_a[i*AW +: AW] = 5'($urandom_range(0, 31));
        end
      end
      cur_rr = (c >= 10000) || ($urandom_range(0, 3) != 0);
      bus.req_valid = cur_v;
      bus.req_addr  = cur_a;
      bus.rsp_ready = cur_rr;
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      chk("soak_grant_onehot",
          64'(((bus.req_ready & ~bus.req_valid) == 0) && ($countones(bus.req_ready) <= 1)), 1);
      if (prev_v && !prev_rr) begin
        chk("soak_stall_valid", bus.rsp_valid, 1);
        chk("soak_stall_fields", {bus.rsp_id, bus.rsp_addr, bus.rsp_data},
            {prev_id, prev_addr, prev_data});
      end
      if (bus.rsp_valid && cur_rr) begin
        hit = 1'b0;
        for (int s = 0; s < sb.size(); s++) begin
          if (!hit && sb[s].id == bus.rsp_id) begin
            hit = 1'b1;
            chk("soak_rsp_addr", bus.rsp_addr, sb[s].addr);
            chk("soak_rsp_data", bus.rsp_data, rf_val(sb[s].addr));
            sb.delete(s);
          end
        end
        chk("soak_rsp_expected", hit, 1);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          sb.push_back('{id: 2'(i), addr: cur_a[i*AW +: AW]});
          for (int j = 0; j < NREQ; j++)
            if (j != i && cur_v[j] && !acc[j]) wait_cnt[j]++;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] || !cur_v[i]) wait_cnt[i] = 0;
        if (wait_cnt[i] >= NREQ) begin
          chk($sformatf("soak_starve[%0d]", i), 64'(wait_cnt[i]), NREQ - 1);
          wait_cnt[i] = 0;
        end
      end
      prev_v = bus.rsp_valid; prev_rr = cur_rr;
      prev_id = bus.rsp_id; prev_addr = bus.rsp_addr; prev_data = bus.rsp_data;
    end
    chk("soak_drain", 64'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
